// File: rtl/iomem_timer.sv
// iomem_timer: memory-mapped down-counting timer responding on the SoC iomem bus.
// Optional feature: define IOMEM_TIMER_PRESCALER_EN to add the 16-bit PRESCALE
// register (offset 0x10) and its prescale counter; otherwise the timer ticks every cycle.
module iomem_timer #(
    parameter logic [31:0] BASE_ADDR = 32'h0300_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        iomem_valid,
    input  logic [3:0]  iomem_wstrb,
    input  logic [31:0] iomem_addr,
    input  logic [31:0] iomem_wdata,
    output logic        iomem_ready,
    output logic [31:0] iomem_rdata,
    output logic        irq_out
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = 4;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned PRE_W  = 16;

    localparam logic [IDX_W-1:0] IDX_CTRL     = IDX_W'(0);
    localparam logic [IDX_W-1:0] IDX_COUNT    = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_RELOAD   = IDX_W'(2);
    localparam logic [IDX_W-1:0] IDX_STATUS   = IDX_W'(3);
`ifdef IOMEM_TIMER_PRESCALER_EN
    localparam logic [IDX_W-1:0] IDX_PRESCALE = IDX_W'(4);
`endif

    // Architectural state
    logic              en;
    logic              autoreload;
    logic              irqen;
    logic [DATA_W-1:0] count;
    logic [DATA_W-1:0] reload;
    logic              expired;
`ifdef IOMEM_TIMER_PRESCALER_EN
    logic [PRE_W-1:0]  prescale;
    logic [PRE_W-1:0]  pcnt;
    logic [PRE_W-1:0]  prescale_nxt;
    logic [PRE_W-1:0]  pcnt_nxt;
`endif

    // Next-state and decode signals
    logic              sel_c;
    logic              access_c;
    logic              wr_c;
    logic [IDX_W-1:0]  widx_c;
    logic              tick_c;
    logic              step_c;
    logic              expire_c;
    logic              en_nxt;
    logic              autoreload_nxt;
    logic              irqen_nxt;
    logic [DATA_W-1:0] count_nxt;
    logic [DATA_W-1:0] reload_nxt;
    logic              expired_nxt;
    logic [DATA_W-1:0] rd_c;

    // Address bits that do not take part in register selection
    logic unused_addr_bits;
    assign unused_addr_bits = ^{iomem_addr[7:5], iomem_addr[1:0]};

    // Merge write data into an existing word under per-byte strobes
    function automatic logic [DATA_W-1:0] merge_bytes(
        input logic [DATA_W-1:0] old,
        input logic [DATA_W-1:0] wd,
        input logic [STRB_W-1:0] strb
    );
        logic [DATA_W-1:0] res;
        res = old;
        for (int i = 0; i < int'(STRB_W); i++) begin
            if (strb[i]) res[8*i +: 8] = wd[8*i +: 8];
        end
        return res;
    endfunction

    // Bus decode: an access is the first cycle of a selected request
    always_comb begin
        sel_c    = iomem_valid && (iomem_addr[31:8] == BASE_ADDR[31:8]);
        access_c = sel_c && !iomem_ready;
        wr_c     = access_c && (iomem_wstrb != '0);
        widx_c   = iomem_addr[4:2];
    end

    // Tick source: prescaled when the prescaler is built in, every cycle otherwise
`ifdef IOMEM_TIMER_PRESCALER_EN
    always_comb begin
        tick_c       = (pcnt == prescale);
        prescale_nxt = prescale;
        pcnt_nxt     = pcnt;
        if (en) pcnt_nxt = tick_c ? '0 : PRE_W'(pcnt + PRE_W'(1));
        if (wr_c && (widx_c == IDX_PRESCALE)) begin
            prescale_nxt = merge_bytes({16'd0, prescale}, iomem_wdata, iomem_wstrb)[PRE_W-1:0];
            pcnt_nxt     = '0;
        end
    end
`else
    always_comb begin
        tick_c = 1'b1;
    end
`endif

    // Counter, control and status next state; bus writes layered over tick updates
    always_comb begin
        step_c         = en && tick_c;
        expire_c       = step_c && (count == '0);
        en_nxt         = en;
        autoreload_nxt = autoreload;
        irqen_nxt      = irqen;
        count_nxt      = count;
        reload_nxt     = reload;
        expired_nxt    = expired;

        if (step_c) begin
            if (count != '0)     count_nxt = count - DATA_W'(1);
            else if (autoreload) count_nxt = reload;
            else                 en_nxt    = 1'b0;
        end

        if (wr_c && (widx_c == IDX_CTRL) && iomem_wstrb[0]) begin
            en_nxt         = iomem_wdata[0];
            autoreload_nxt = iomem_wdata[1];
            irqen_nxt      = iomem_wdata[2];
        end
        if (wr_c && (widx_c == IDX_COUNT))
            count_nxt = merge_bytes(count, iomem_wdata, iomem_wstrb);
        if (wr_c && (widx_c == IDX_RELOAD))
            reload_nxt = merge_bytes(reload, iomem_wdata, iomem_wstrb);
        if (wr_c && (widx_c == IDX_STATUS) && iomem_wstrb[0] && iomem_wdata[0])
            expired_nxt = 1'b0;
        // A same-cycle expiry wins over a software clear
        if (expire_c)
            expired_nxt = 1'b1;
    end

    // Read mux over the pre-edge register values
    always_comb begin
        rd_c = '0;
        case (widx_c)
            IDX_CTRL:     rd_c = {29'd0, irqen, autoreload, en};
            IDX_COUNT:    rd_c = count;
            IDX_RELOAD:   rd_c = reload;
            IDX_STATUS:   rd_c = {31'd0, expired};
`ifdef IOMEM_TIMER_PRESCALER_EN
            IDX_PRESCALE: rd_c = {16'd0, prescale};
`endif
            default:      rd_c = '0;
        endcase
    end

    // State and registered bus/interrupt outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            en          <= 1'b0;
            autoreload  <= 1'b0;
            irqen       <= 1'b0;
            count       <= '0;
            reload      <= '0;
            expired     <= 1'b0;
            iomem_ready <= 1'b0;
            iomem_rdata <= '0;
            irq_out     <= 1'b0;
`ifdef IOMEM_TIMER_PRESCALER_EN
            prescale    <= '0;
            pcnt        <= '0;
`endif
        end else begin
            en          <= en_nxt;
            autoreload  <= autoreload_nxt;
            irqen       <= irqen_nxt;
            count       <= count_nxt;
            reload      <= reload_nxt;
            expired     <= expired_nxt;
            iomem_ready <= access_c;
            iomem_rdata <= access_c ? rd_c : '0;
            irq_out     <= expire_c && irqen;
`ifdef IOMEM_TIMER_PRESCALER_EN
            prescale    <= prescale_nxt;
            pcnt        <= pcnt_nxt;
`endif
        end
    end

endmodule

// File: doc/iomem_timer.md
# iomem_timer

Memory-mapped down-counting timer that acts as a responder on the SoC's iomem bus, the external-peripheral port that the CPU drives through `iomem_valid`, `iomem_wstrb`, `iomem_addr` and `iomem_wdata` and that returns `iomem_ready` and `iomem_rdata`. The block decodes its own 256-byte window and completes each transfer with a one-cycle ready pulse. It counts enabled ticks down to zero and raises a sticky expiry flag plus a one-cycle interrupt pulse. The interrupt is wired to one of the SoC's external IRQ inputs (`irq_5`).

## Interface
Parameters:
- `BASE_ADDR`, default 32'h0300_0000: window base; decode compares `iomem_addr[31:8]` with `BASE_ADDR[31:8]`.

Ports:
- `clk`  in  1  clock, rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `iomem_valid`  in  1  transfer request; held high until ready.
- `iomem_wstrb`  in  4  byte write strobes; 0 = read.
- `iomem_addr`  in  32  byte address.
- `iomem_wdata`  in  32  write data.
- `iomem_ready`  out  1  transfer complete, one-cycle pulse.
- `iomem_rdata`  out  32  read data; valid only while ready, 0 otherwise.
- `irq_out`  out  1  expiry interrupt pulse.

## Operation
- `sel = iomem_valid && addr[31:8]==BASE_ADDR[31:8]`. The block never drives ready for addresses outside its window.
- Register map, word index `addr[4:2]`:
  - 0x00 CTRL: bit0 EN, bit1 AUTORELOAD, bit2 IRQEN. Only `wstrb[0]` is honoured; the remaining bits read 0.
  - 0x04 COUNT: 32-bit current value. Writes use per-byte strobes.
  - 0x08 RELOAD: 32-bit reload value. Writes use per-byte strobes.
  - 0x0C STATUS: bit0 EXPIRED, sticky. Writing 1 to bit0 with `wstrb[0]` set clears it.
  - 0x10 PRESCALE: present only with the macro; otherwise it behaves as an unmapped word.
  - Other words: writes are ignored, reads return 0, and ready is still given.
- Tick behaviour, applied when EN=1 and tick=1:
  - COUNT≠0: COUNT decrements by 1.
  - COUNT==0: EXPIRED is set, `irq_out` pulses if IRQEN=1, then COUNT←RELOAD if AUTORELOAD=1, else EN←0 and COUNT stays at 0.
- Period with AUTORELOAD = (RELOAD+1) ticks.
- Simultaneous events:
  - A bus write to COUNT overrides the tick update in the same cycle.
  - A bus write clearing EXPIRED loses to a set in the same cycle.
  - A bus write to CTRL takes effect from the next cycle; the tick in the write cycle uses the old CTRL.
- Arithmetic is unsigned 32-bit. There is no underflow wrap, because zero triggers expiry rather than decrement.

## Timing
- Reset values: all registers 0, `iomem_ready`=0, `iomem_rdata`=0, `irq_out`=0, prescale counter 0.
- Handshake:
  - Ready is registered: `ready <= sel && !ready`.
  - Ready rises exactly 1 cycle after `sel` is first sampled and lasts 1 cycle.
  - Back-to-back requests therefore get ready at most every other cycle.
- Register writes and read-data capture both happen at the edge that raises ready. Read data reflects register values from before that edge.
- `irq_out` is registered. It is high for exactly the one cycle after the expiring edge, and EXPIRED is visible on that same cycle.
- If `resetn` falls mid-transfer, ready and rdata clear immediately. The transfer is lost and no write occurs unless the write edge has already passed.

## Configuration
- `IOMEM_TIMER_PRESCALER_EN` defined:
  - Adds the 16-bit PRESCALE register and a 16-bit prescale counter.
  - tick=1 when the counter equals PRESCALE; the counter then returns to 0, otherwise it increments. The counter runs only while EN=1.
  - Writing PRESCALE zeroes the counter.
  - Tick period = PRESCALE+1 cycles.
- Undefined: tick=1 every cycle. Offset 0x10 is unmapped, reads 0, and writes are ignored.

## Test plan
- Reset, then read CTRL/COUNT/RELOAD/STATUS → each ready arrives 1 cycle after valid, and all rdata = 0.
- Write RELOAD=3 and COUNT=3, then CTRL=0x7 → `irq_out` pulses every 4 cycles, EXPIRED=1, and COUNT sequence 3,2,1,0,3.
- Write COUNT=2, then CTRL=0x5 (one-shot) → single irq pulse, after which EN reads 0 and COUNT holds 0.
- Write STATUS=1 on the same edge as an expiry → EXPIRED remains 1; a later clear reads 0.
- Valid to 0x0400_0000 → `iomem_ready` never asserts. Read of 0x0300_0018 → ready with rdata 0.
- With the macro, PRESCALE=4, COUNT=1, CTRL=0x5 → irq 10 cycles after EN is set; without the macro, a write to 0x10 followed by a read returns 0.
